// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single combinational ALU.
// One operation in flight at a time: grant, execute for one cycle, hold the result until consumed.
module alu_arbiter #(
    parameter int RR_MODE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid0,
    input  logic         req_valid1,
    input  logic [2:0]   req_op0,
    input  logic [2:0]   req_op1,
    input  logic [7:0]   req_a0,
    input  logic [7:0]   req_b0,
    input  logic [7:0]   req_a1,
    input  logic [7:0]   req_b1,
    input  logic         req_cin0,
    input  logic         req_cin1,
    output logic         req_ready0,
    output logic         req_ready1,
    output logic         rsp_valid0,
    output logic         rsp_valid1,
    input  logic         rsp_ready0,
    input  logic         rsp_ready1,
    output logic [8:0]   rsp_data,
    output logic [120:1] alu_oper,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output logic         alu_cin,
    input  logic [7:0]   alu_sum,
    input  logic         alu_cout,
    output logic         busy,
    output logic         owner
);

    // state | meaning
    // IDLE  | waiting for a request; grant happens combinationally here
    // EXEC  | latched operands drive the ALU; result captured at cycle end
    // RESP  | result held for the owner until its rsp_ready
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state, state_nxt;
    logic        grant_any;
    logic        grant_idx;
    logic        owner_q;
    logic        last_q;
    logic [2:0]  op_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic        cin_q;
    logic [8:0]  rsp_data_q;

    function automatic logic [119:0] op_name(input logic [2:0] op);
        logic [119:0] name;
        name = '0;
        case (op)
            3'd0: name = {96'd0, "and"};
            3'd1: name = {56'd0, "subtract"};
            3'd2: name = {40'd0, "subtract_a"};
            3'd3: name = {80'd0, "or_ab"};
            3'd4: name = {72'd0, "and_ab"};
            3'd5: name = {72'd0, "not_ab"};
            3'd6: name = {88'd0, "exor"};
            3'd7: name = {80'd0, "exnor"};
            default: name = {96'd0, "and"};
        endcase
        return name;
    endfunction

    always_comb begin
        state_nxt = state;
        grant_any = 1'b0;
        grant_idx = owner_q;
        case (state)
            IDLE: begin
                if (req_valid0 || req_valid1) begin
                    grant_any = 1'b1;
                    state_nxt = EXEC;
                    if (req_valid0 && req_valid1) begin
                        if (RR_MODE != 0) grant_idx = ~last_q;
                        else              grant_idx = 1'b0;
                    end else begin
                        grant_idx = req_valid1;
                    end
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (owner_q ? rsp_ready1 : rsp_ready0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            op_q       <= 3'd0;
            a_q        <= 8'd0;
            b_q        <= 8'd0;
            cin_q      <= 1'b0;
            rsp_data_q <= 9'd0;
        end else begin
            state <= state_nxt;
            if (grant_any) begin
                owner_q <= grant_idx;
                last_q  <= grant_idx;
                if (grant_idx) begin
                    op_q  <= req_op1;
                    a_q   <= req_a1;
                    b_q   <= req_b1;
                    cin_q <= req_cin1;
                end else begin
                    op_q  <= req_op0;
                    a_q   <= req_a0;
                    b_q   <= req_b0;
                    cin_q <= req_cin0;
                end
            end
            if (state == EXEC) rsp_data_q <= {alu_cout, alu_sum};
        end
    end

    // Gated by rst_n so a held request cannot show ready while reset is asserted.
    assign req_ready0 = rst_n && grant_any && !grant_idx;
    assign req_ready1 = rst_n && grant_any &&  grant_idx;
    assign rsp_valid0 = (state == RESP) && !owner_q;
    assign rsp_valid1 = (state == RESP) &&  owner_q;
    assign rsp_data   = rsp_data_q;
    assign alu_oper   = op_name(op_q);
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_cin    = cin_q;
    assign busy       = (state != IDLE);
    assign owner      = owner_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: round-robin instance plus a fixed-priority
// instance sharing the same stimulus, with a bench-driven ALU stub.
module tb_alu_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid0, req_valid1;
    logic [2:0]   req_op0, req_op1;
    logic [7:0]   req_a0, req_b0, req_a1, req_b1;
    logic         req_cin0, req_cin1;
    logic         rsp_ready0, rsp_ready1;
    logic [7:0]   alu_sum;
    logic         alu_cout;

    logic         req_ready0, req_ready1, rsp_valid0, rsp_valid1;
    logic [8:0]   rsp_data;
    logic [120:1] alu_oper;
    logic [7:0]   alu_a, alu_b;
    logic         alu_cin, busy, owner;

    logic         fp_req_ready0, fp_req_ready1, fp_rsp_valid0, fp_rsp_valid1;
    logic [8:0]   fp_rsp_data;
    logic [120:1] fp_alu_oper;
    logic [7:0]   fp_alu_a, fp_alu_b;
    logic         fp_alu_cin, fp_busy, fp_owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.RR_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid0(req_valid0), .req_valid1(req_valid1),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_cin0(req_cin0), .req_cin1(req_cin1),
        .req_ready0(req_ready0), .req_ready1(req_ready1),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
        .rsp_data(rsp_data), .alu_oper(alu_oper),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_sum(alu_sum), .alu_cout(alu_cout),
        .busy(busy), .owner(owner)
    );

    alu_arbiter #(.RR_MODE(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req_valid0(req_valid0), .req_valid1(req_valid1),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_cin0(req_cin0), .req_cin1(req_cin1),
        .req_ready0(fp_req_ready0), .req_ready1(fp_req_ready1),
        .rsp_valid0(fp_rsp_valid0), .rsp_valid1(fp_rsp_valid1),
        .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
        .rsp_data(fp_rsp_data), .alu_oper(fp_alu_oper),
        .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_cin(fp_alu_cin),
        .alu_sum(alu_sum), .alu_cout(alu_cout),
        .busy(fp_busy), .owner(fp_owner)
    );

    function automatic logic [119:0] exp_oper(input logic [2:0] op);
        logic [119:0] s;
        s = '0;
        case (op)
            3'd0: s = {96'd0, "and"};
            3'd1: s = {56'd0, "subtract"};
            3'd2: s = {40'd0, "subtract_a"};
            3'd3: s = {80'd0, "or_ab"};
            3'd4: s = {72'd0, "and_ab"};
            3'd5: s = {72'd0, "not_ab"};
            3'd6: s = {88'd0, "exor"};
            3'd7: s = {80'd0, "exnor"};
            default: s = '0;
        endcase
        return s;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_valid0 = 0; req_valid1 = 0;
        req_op0 = 0; req_op1 = 0;
        req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
        req_cin0 = 0; req_cin1 = 0;
        rsp_ready0 = 1; rsp_ready1 = 1;
        alu_sum = 0; alu_cout = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 0;
        req_valid0 = 1;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner got=%b exp=0", owner); end
        checks++; if (rsp_data !== 9'h000) begin errors++; $display("FAIL reset_rsp_data got=%h exp=000", rsp_data); end
        checks++; if ({alu_a, alu_b, alu_cin} !== 17'd0) begin errors++; $display("FAIL reset_alu_drive got=%h/%h/%b exp=0", alu_a, alu_b, alu_cin); end
        checks++; if (alu_oper !== exp_oper(3'd0)) begin errors++; $display("FAIL reset_alu_oper got=%h exp=%h", alu_oper, exp_oper(3'd0)); end
        checks++; if ({rsp_valid0, rsp_valid1, req_ready0, req_ready1} !== 4'b0000) begin errors++; $display("FAIL reset_handshake got=%b exp=0000", {rsp_valid0, rsp_valid1, req_ready0, req_ready1}); end
        req_valid0 = 0;
        @(posedge clk);
        #1 rst_n = 1;
        #1;
    endtask

    task automatic test_single;
        req_valid0 = 1; req_op0 = 3'd1; req_a0 = 8'h0C; req_b0 = 8'h20; req_cin0 = 1;
        alu_sum = 8'hEC; alu_cout = 1;
        rsp_ready0 = 0; rsp_ready1 = 1;
        #1;
        checks++; if ({req_ready0, req_ready1} !== 2'b10) begin errors++; $display("FAIL single_grant got=%b exp=10", {req_ready0, req_ready1}); end
        tick();
        req_valid0 = 0;
        #1;
        checks++; if (alu_oper !== exp_oper(3'd1)) begin errors++; $display("FAIL single_exec_oper got=%h exp=%h", alu_oper, exp_oper(3'd1)); end
        checks++; if ({alu_a, alu_b, alu_cin} !== {8'h0C, 8'h20, 1'b1}) begin errors++; $display("FAIL single_exec_operands got=%h/%h/%b exp=0c/20/1", alu_a, alu_b, alu_cin); end
        checks++; if ({busy, rsp_valid0, req_ready0} !== 3'b100) begin errors++; $display("FAIL single_exec_ctrl got=%b exp=100", {busy, rsp_valid0, req_ready0}); end
        tick();
        checks++; if ({rsp_valid0, rsp_valid1} !== 2'b10) begin errors++; $display("FAIL single_rsp_valid got=%b exp=10", {rsp_valid0, rsp_valid1}); end
        checks++; if (rsp_data !== 9'h1EC) begin errors++; $display("FAIL single_rsp_data got=%h exp=1ec", rsp_data); end
        tick();
        checks++; if (rsp_valid0 !== 1'b1) begin errors++; $display("FAIL single_nonowner_ready_ignored got=%b exp=1", rsp_valid0); end
        rsp_ready0 = 1;
        tick();
        checks++; if ({busy, rsp_valid0} !== 2'b00) begin errors++; $display("FAIL single_return_idle got=%b exp=00", {busy, rsp_valid0}); end
        checks++; if ({alu_a, alu_b} !== {8'h0C, 8'h20} || alu_oper !== exp_oper(3'd1)) begin errors++; $display("FAIL single_alu_hold got=%h/%h exp=0c/20", alu_a, alu_b); end
    endtask

    task automatic test_contention;
        int g_rr[$];
        int c_rr[$];
        int g_fp[$];
        do_reset();
        req_op0 = 3'd2; req_a0 = 8'h01; req_b0 = 8'h02; req_cin0 = 0;
        req_op1 = 3'd5; req_a1 = 8'h03; req_b1 = 8'h04; req_cin1 = 1;
        alu_sum = 8'h11; alu_cout = 0;
        req_valid0 = 1; req_valid1 = 1;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (req_ready0 && req_ready1) begin
                checks++; errors++; $display("FAIL contention_onehot cycle=%0d both ready", c);
            end
            if (req_ready0) begin g_rr.push_back(0); c_rr.push_back(c); end
            if (req_ready1) begin g_rr.push_back(1); c_rr.push_back(c); end
            if (fp_req_ready0) g_fp.push_back(0);
            if (fp_req_ready1) g_fp.push_back(1);
            tick();
        end
        req_valid0 = 0; req_valid1 = 0;
        #1;
        checks++;
        if (g_rr.size() != 4) begin
            errors++; $display("FAIL rr_grant_count got=%0d exp=4", g_rr.size());
        end else if (g_rr[0] != 0 || g_rr[1] != 1 || g_rr[2] != 0 || g_rr[3] != 1) begin
            errors++; $display("FAIL rr_grant_order got=%0d%0d%0d%0d exp=0101", g_rr[0], g_rr[1], g_rr[2], g_rr[3]);
        end
        checks++;
        if (c_rr.size() != 4 || c_rr[0] != 0 || c_rr[1] != 3 || c_rr[2] != 6 || c_rr[3] != 9) begin
            errors++; $display("FAIL rr_issue_interval got_count=%0d exp_cycles=0,3,6,9", c_rr.size());
        end
        checks++;
        if (g_fp.size() != 4) begin
            errors++; $display("FAIL fp_grant_count got=%0d exp=4", g_fp.size());
        end else if (g_fp[0] != 0 || g_fp[1] != 0 || g_fp[2] != 0 || g_fp[3] != 0) begin
            errors++; $display("FAIL fp_grant_order got=%0d%0d%0d%0d exp=0000", g_fp[0], g_fp[1], g_fp[2], g_fp[3]);
        end
        checks++; if ({owner, alu_a, alu_b, alu_cin} !== {1'b1, 8'h03, 8'h04, 1'b1}) begin errors++; $display("FAIL rr_last_owner got=%b/%h/%h exp=1/03/04", owner, alu_a, alu_b); end
        checks++; if ({fp_owner, fp_busy, fp_rsp_valid0, fp_rsp_valid1} !== 4'b0000) begin errors++; $display("FAIL fp_end_ctrl got=%b exp=0000", {fp_owner, fp_busy, fp_rsp_valid0, fp_rsp_valid1}); end
        checks++; if (fp_rsp_data !== 9'h011 || fp_alu_oper !== exp_oper(3'd2)) begin errors++; $display("FAIL fp_end_data got=%h exp=011", fp_rsp_data); end
        checks++; if ({fp_alu_a, fp_alu_b, fp_alu_cin} !== {8'h01, 8'h02, 1'b0}) begin errors++; $display("FAIL fp_end_operands got=%h/%h/%b exp=01/02/0", fp_alu_a, fp_alu_b, fp_alu_cin); end
    endtask

    task automatic test_backpressure;
        do_reset();
        req_valid1 = 1; req_op1 = 3'd3; req_a1 = 8'h5A; req_b1 = 8'hA5;
        #1;
        checks++; if ({req_ready0, req_ready1} !== 2'b01) begin errors++; $display("FAIL bp_lone_grant got=%b exp=01", {req_ready0, req_ready1}); end
        tick();
        req_valid1 = 0; req_valid0 = 1; req_op0 = 3'd4; req_a0 = 8'h77;
        rsp_ready1 = 0; rsp_ready0 = 1;
        alu_sum = 8'h5A; alu_cout = 0;
        #1;
        checks++; if (req_ready0 !== 1'b0) begin errors++; $display("FAIL bp_exec_ready got=%b exp=0", req_ready0); end
        tick();
        alu_sum = 8'hFF; alu_cout = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({rsp_valid1, rsp_valid0, busy, req_ready0} !== 4'b1010 || rsp_data !== 9'h05A) begin
                errors++; $display("FAIL bp_hold cycle=%0d got=%b data=%h exp=1010 data=05a", i, {rsp_valid1, rsp_valid0, busy, req_ready0}, rsp_data);
            end
            tick();
        end
        rsp_ready1 = 1;
        #1;
        checks++; if (rsp_valid1 !== 1'b1) begin errors++; $display("FAIL bp_pre_consume got=%b exp=1", rsp_valid1); end
        tick();
        checks++; if ({req_ready0, busy, rsp_valid1} !== 3'b100) begin errors++; $display("FAIL bp_post_consume got=%b exp=100", {req_ready0, busy, rsp_valid1}); end
        tick();
        req_valid0 = 0;
        #1;
        checks++; if ({owner, alu_a} !== {1'b0, 8'h77}) begin errors++; $display("FAIL bp_req0_granted got=%b/%h exp=0/77", owner, alu_a); end
        tick();
        tick();
    endtask

    task automatic test_mid_reset;
        do_reset();
        req_valid0 = 1; req_op0 = 3'd6; req_a0 = 8'h33; req_b0 = 8'h0F;
        alu_sum = 8'h3C; alu_cout = 0;
        tick();
        req_valid0 = 0;
        #1;
        checks++; if (busy !== 1'b1 || alu_oper !== exp_oper(3'd6)) begin errors++; $display("FAIL mid_exec got busy=%b oper=%h exp busy=1 exor", busy, alu_oper); end
        #1 rst_n = 0;
        #1;
        checks++;
        if ({busy, owner, rsp_valid0, rsp_valid1, alu_a, alu_b, alu_cin} !== 21'd0 || rsp_data !== 9'd0 || alu_oper !== exp_oper(3'd0)) begin
            errors++; $display("FAIL mid_async_reset got busy=%b a=%h b=%h data=%h oper=%h exp all reset", busy, alu_a, alu_b, rsp_data, alu_oper);
        end
        tick();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({rsp_valid0, rsp_valid1, busy} !== 3'b000) begin
                errors++; $display("FAIL mid_no_rsp cycle=%0d got=%b exp=000", i, {rsp_valid0, rsp_valid1, busy});
            end
            tick();
        end
        req_valid0 = 1; req_valid1 = 1;
        #1;
        checks++; if ({req_ready0, req_ready1} !== 2'b10) begin errors++; $display("FAIL mid_next_contention got=%b exp=10", {req_ready0, req_ready1}); end
        req_valid0 = 0; req_valid1 = 0;
        #1;
        tick();
    endtask

    task automatic test_opcode_sweep;
        do_reset();
        for (int op = 0; op < 8; op++) begin
            req_valid1 = 1; req_op1 = 3'(op); req_a1 = 8'(op * 3);
            tick();
            req_valid1 = 0;
            #1;
            checks++;
            if (alu_oper !== exp_oper(3'(op)) || alu_a !== 8'(op * 3)) begin
                errors++; $display("FAIL sweep_oper op=%0d got=%h exp=%h", op, alu_oper, exp_oper(3'(op)));
            end
            tick();
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_mid_reset();
        test_opcode_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
